spart_rx: RTL

SPART_RX -- requirements
Module: spart_rx

---
 rtl/spart_rx_if.sv | 19 +
 rtl/spart_rx.sv | 124 ++++++++++++
 2 files changed

// File: rtl/spart_rx_if.sv
// Bus-side signals of the SPART receiver: baud divisor, read strobe, received byte and status.
interface spart_rx_if;
    logic [15:0] divisor;
    logic        rd;
    logic [7:0]  rx_data;
    logic        rda;
    logic        frame_err;
    logic        overrun;

    modport master (
        output divisor, rd,
        input  rx_data, rda, frame_err, overrun
    );

    modport slave (
        input  divisor, rd,
        output rx_data, rda, frame_err, overrun
    );
endinterface

// File: rtl/spart_rx.sv
// SPART serial receiver: 16x oversampled 8N1 framing with a one-byte receive buffer,
// data-available, framing-error and sticky overrun flags.
module spart_rx (
    input  logic      clk,
    input  logic      rst,
    input  logic      rxd,
    spart_rx_if.slave bus
);
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t              state;
    logic                rxd_p0;
    logic                rxd_s;
    logic [15:0]         baud_cnt;
    logic [3:0]          tick_num;
    logic [2:0]          bit_idx;
    logic [DATA_W-1:0]   shift_q;
    logic                tick;
    logic                start_det;
    logic                load;

    assign tick      = (baud_cnt == 16'd0);
    assign start_det = (state == IDLE) && !rxd_s;
    assign load      = (state == STOP) && tick && (tick_num == 4'd15);

    // Synchronizer resets to the idle-line level so reset release never looks like a start edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rxd_p0 <= 1'b1;
            rxd_s  <= 1'b1;
        end else begin
            rxd_p0 <= rxd;
            rxd_s  <= rxd_p0;
        end
    end

    // Free-running baud tick; start detection re-phases it to the falling edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            baud_cnt <= 16'd0;
        end else if (start_det || tick) begin
            baud_cnt <= bus.divisor;
        end else begin
            baud_cnt <= baud_cnt - 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick_num <= 4'd0;
            bit_idx  <= 3'd0;
            shift_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!rxd_s) begin
                        state    <= START;
                        tick_num <= 4'd0;
                        bit_idx  <= 3'd0;
                    end
                end
                START: begin
                    if (tick) begin
                        if (tick_num == 4'd7) begin
                            tick_num <= 4'd0;
                            state    <= rxd_s ? IDLE : DATA;
                        end else begin
                            tick_num <= tick_num + 4'd1;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        tick_num <= tick_num + 4'd1;
                        if (tick_num == 4'd15) begin
                            shift_q <= {rxd_s, shift_q[DATA_W-1:1]};
                            bit_idx <= bit_idx + 3'd1;
                            if (bit_idx == 3'd7) begin
                                state <= STOP;
                            end
                        end
                    end
                end
                STOP: begin
                    if (tick) begin
                        tick_num <= tick_num + 4'd1;
                        if (tick_num == 4'd15) begin
                            state <= rxd_s ? IDLE : BREAK;
                        end
                    end
                end
                BREAK: begin
                    if (rxd_s) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A load takes priority over a simultaneous read; overrun only arises from an unread byte.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bus.rx_data   <= '0;
            bus.rda       <= 1'b0;
            bus.frame_err <= 1'b0;
            bus.overrun   <= 1'b0;
        end else if (load) begin
            bus.rx_data   <= shift_q;
            bus.rda       <= 1'b1;
            bus.frame_err <= ~rxd_s;
            if (bus.rda && !bus.rd) begin
                bus.overrun <= 1'b1;
            end
        end else if (bus.rd && bus.rda) begin
            bus.rda     <= 1'b0;
            bus.overrun <= 1'b0;
        end
    end
endmodule
